// File: rtl/condlogic_if.sv
// Bus between the decoder/main FSM and the conditional-execution unit.
// The master (decoder/FSM side) drives the requests; the slave returns the gated strobes.
interface condlogic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx
  );
endinterface

// File: rtl/condlogic.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field and
// gates the FSM's write requests with the registered pass/fail result.
module condlogic #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input logic        clk,
  input logic        reset,
  condlogic_if.slave bus
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_delayed_q, cond_ex_delayed_d;
  logic       cond_ex;
  logic [1:0] flag_write;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flags update in the execute cycle itself, so the un-delayed pass/fail gates them.
  assign flag_write = bus.FlagW & {2{cond_ex}};

  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = bus.ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    cond_ex_delayed_d = cond_ex;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q           <= FLAGS_RESET;
      cond_ex_delayed_q <= 1'b0;
    end else begin
      flags_q           <= flags_d;
      cond_ex_delayed_q <= cond_ex_delayed_d;
    end
  end

  // Later states see the pass/fail of the instruction's own pre-update flags;
  // the cleared delayed flop also kills pending strobes as soon as reset rises.
  assign bus.PCWrite  = bus.NextPC | (bus.PCS & cond_ex_delayed_q);
  assign bus.RegWrite = bus.RegW & cond_ex_delayed_q;
  assign bus.MemWrite = bus.MemW & cond_ex_delayed_q;
  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex;

endmodule

// File: tb/tb_condlogic.sv
// Scoreboard bench for condlogic: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_condlogic;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  condlogic_if bus ();

  condlogic #(.FLAGS_RESET(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // care bits: [4]=Flags [3]=CondEx [2]=PCWrite [1]=RegWrite [0]=MemWrite
  typedef struct {
    string      name;
    logic [4:0] care;
    logic [3:0] flags;
    logic       cond_ex;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.care[4]) check({e.name, ".Flags"},    bus.Flags,           e.flags);
      if (e.care[3]) check({e.name, ".CondEx"},   {3'b0, bus.CondEx},   {3'b0, e.cond_ex});
      if (e.care[2]) check({e.name, ".PCWrite"},  {3'b0, bus.PCWrite},  {3'b0, e.pc_write});
      if (e.care[1]) check({e.name, ".RegWrite"}, {3'b0, bus.RegWrite}, {3'b0, e.reg_write});
      if (e.care[0]) check({e.name, ".MemWrite"}, {3'b0, bus.MemWrite}, {3'b0, e.mem_write});
    end
  end

  // One cycle of stimulus: drive just after the rising edge, expectations hold at the following negedge.
  task automatic step(
    input string      name,
    input logic       rst_v,
    input logic [3:0] cond,
    input logic [1:0] flagw,
    input logic [3:0] aluf,
    input logic       pcs,
    input logic       nextpc,
    input logic       regw,
    input logic       memw,
    input logic [4:0] care,
    input logic [3:0] e_flags,
    input logic       e_cex,
    input logic       e_pcw,
    input logic       e_rw,
    input logic       e_mw
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst_v;
    bus.Cond     = cond;
    bus.FlagW    = flagw;
    bus.ALUFlags = aluf;
    bus.PCS      = pcs;
    bus.NextPC   = nextpc;
    bus.RegW     = regw;
    bus.MemW     = memw;
    e.name      = name;
    e.care      = care;
    e.flags     = e_flags;
    e.cond_ex   = e_cex;
    e.pc_write  = e_pcw;
    e.reg_write = e_rw;
    e.mem_write = e_mw;
    sb.push_back(e);
  endtask

  // Load flags via an always-executing instruction, then check CondEx for cond next cycle.
  task automatic cond_row(input logic [3:0] f, input logic [3:0] cond, input logic exp_cex);
    step("load", 0, 4'b1110, 2'b11, f, 0, 0, 0, 0, 5'b00000, 4'h0, 0, 0, 0, 0);
    step($sformatf("cond_%b_flags_%b", cond, f), 0, cond, 2'b00, 4'h0, 0, 0, 0, 0,
         5'b11000, f, exp_cex, 0, 0, 0);
  endtask

  typedef struct packed {
    logic [3:0] f;
    logic [3:0] cond;
    logic       cex;
  } row_t;

  row_t rows[23] = '{
    '{4'b1000, 4'b1011, 1'b1}, '{4'b1000, 4'b1010, 1'b0},
    '{4'b1001, 4'b1010, 1'b1}, '{4'b1001, 4'b1011, 1'b0},
    '{4'b0100, 4'b1100, 1'b0}, '{4'b0100, 4'b1101, 1'b1},
    '{4'b0010, 4'b1000, 1'b1}, '{4'b0010, 4'b1001, 1'b0},
    '{4'b0110, 4'b1000, 1'b0}, '{4'b0110, 4'b1001, 1'b1},
    '{4'b0000, 4'b0000, 1'b0}, '{4'b0100, 4'b0000, 1'b1},
    '{4'b0100, 4'b0001, 1'b0}, '{4'b0010, 4'b0010, 1'b1},
    '{4'b0010, 4'b0011, 1'b0}, '{4'b1000, 4'b0100, 1'b1},
    '{4'b1000, 4'b0101, 1'b0}, '{4'b0001, 4'b0110, 1'b1},
    '{4'b0001, 4'b0111, 1'b0}, '{4'b0000, 4'b1100, 1'b1},
    '{4'b1001, 4'b1100, 1'b1}, '{4'b1000, 4'b1101, 1'b1},
    '{4'b0000, 4'b1110, 1'b1}
  };

  initial begin
    bus.Cond = 4'b1110; bus.FlagW = 2'b00; bus.ALUFlags = 4'h0;
    bus.PCS = 0; bus.NextPC = 0; bus.RegW = 0; bus.MemW = 0;

    // reset behaviour and release
    step("rst_hold",   1, 4'b1110, 2'b00, 4'h0, 0, 1, 1, 1, 5'b11111, 4'b0000, 1, 1, 0, 0);
    step("rst_rel1",   0, 4'b1110, 2'b00, 4'h0, 0, 0, 1, 0, 5'b10111, 4'b0000, 0, 0, 0, 0);
    step("rst_rel2",   0, 4'b1110, 2'b00, 4'h0, 0, 0, 1, 0, 5'b00010, 4'b0000, 0, 0, 1, 0);

    // flag write, then EQ passes and NE fails
    step("setZ",       0, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 0, 5'b11010, 4'b0000, 1, 0, 0, 0);
    step("eq",         0, 4'b0000, 2'b00, 4'h0, 0, 0, 0, 0, 5'b11000, 4'b0100, 1, 0, 0, 0);
    step("eq_wb",      0, 4'b1110, 2'b00, 4'h0, 0, 0, 1, 0, 5'b00010, 4'b0000, 0, 0, 1, 0);
    step("ne",         0, 4'b0001, 2'b00, 4'h0, 0, 0, 0, 0, 5'b11000, 4'b0100, 0, 0, 0, 0);
    step("ne_wb",      0, 4'b1110, 2'b00, 4'h0, 0, 0, 1, 0, 5'b00010, 4'b0000, 0, 0, 0, 0);

    // independent flag halves
    step("clr",        0, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0, 5'b10000, 4'b0100, 0, 0, 0, 0);
    step("nz_only",    0, 4'b1110, 2'b10, 4'b1111, 0, 0, 0, 0, 5'b10000, 4'b0000, 0, 0, 0, 0);
    step("cv_only",    0, 4'b1110, 2'b01, 4'b0011, 0, 0, 0, 0, 5'b10000, 4'b1100, 0, 0, 0, 0);
    step("after_cv",   0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 5'b10000, 4'b1111, 0, 0, 0, 0);
    step("hold",       0, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0, 5'b10000, 4'b1111, 0, 0, 0, 0);

    // failed condition blocks flag and write updates
    step("eq_fail",    0, 4'b0000, 2'b11, 4'b1111, 0, 0, 0, 0, 5'b11000, 4'b0000, 0, 0, 0, 0);
    step("blocked",    0, 4'b1111, 2'b00, 4'h0, 1, 0, 0, 1, 5'b11101, 4'b0000, 0, 0, 0, 0);
    step("fetch_pc",   0, 4'b1110, 2'b00, 4'h0, 1, 1, 0, 0, 5'b00100, 4'b0000, 0, 1, 0, 0);
    step("pass_wr",    0, 4'b1110, 2'b00, 4'h0, 1, 0, 1, 1, 5'b00111, 4'b0000, 0, 1, 1, 1);

    foreach (rows[i]) cond_row(rows[i].f, rows[i].cond, rows[i].cex);
    for (int f = 0; f < 16; f++) cond_row(4'(f), 4'b1111, 1'b0);

    // reset asserted between edges while strobes are live
    step("pre_rst",    0, 4'b1110, 2'b11, 4'b1010, 0, 0, 1, 1, 5'b00000, 4'h0, 0, 0, 0, 0);
    step("live",       0, 4'b1110, 2'b00, 4'h0, 0, 0, 1, 1, 5'b10111, 4'b1010, 0, 0, 1, 1);
    step("mid_rst",    1, 4'b1110, 2'b00, 4'h0, 0, 0, 1, 1, 5'b10111, 4'b0000, 0, 0, 0, 0);
    step("post_rst1",  0, 4'b1110, 2'b00, 4'h0, 0, 0, 1, 1, 5'b00011, 4'h0, 0, 0, 0, 0);
    step("post_rst2",  0, 4'b1110, 2'b00, 4'h0, 0, 0, 1, 1, 5'b00011, 4'h0, 0, 0, 1, 1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/condlogic.md
Name: condlogic

Overview:
- Conditional-execution unit of the multi-cycle ARM-subset core. Sits directly downstream of the decoder/main FSM.
- Holds the architectural NZCV flags and evaluates the instruction's 4-bit condition field against them.
- Registers the pass/fail result and gates the FSM's write-enable requests into the final PCWrite/RegWrite/MemWrite strobes for the datapath.

Parameters:
FLAGS_RESET, 4'b0000, reset value of the {N,Z,C,V} flag register

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Cond  input  4  Instr[31:28], condition field
ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
FlagW  input  2  flag write request from the ALU decoder: [1]=N,Z; [0]=C,V
PCS  input  1  PC-source request (Rd==PC write or branch)
NextPC  input  1  unconditional PC update (fetch state)
RegW  input  1  register-file write request from the FSM
MemW  input  1  data-memory write request from the FSM
PCWrite  output  1  PC register enable
RegWrite  output  1  register-file write enable
MemWrite  output  1  data-memory write enable
Flags  output  4  current {N,Z,C,V} register contents (debug/visibility)
CondEx  output  1  combinational condition-pass for the current Cond/Flags

Behaviour:
- Reset is asynchronous and active-high: Flags <= FLAGS_RESET and CondExDelayed <= 0 immediately. While reset is held, RegWrite=0 and MemWrite=0, and PCWrite = NextPC (combinational passthrough).
- CondEx is combinational from Cond and the registered Flags (N=Flags[3], Z=[2], C=[1], V=[0]):
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 is reserved and evaluates to 0 (never executes); no X is propagated.
- FlagWrite[1:0] = FlagW & {2{CondEx}}. This uses the un-delayed CondEx, so flags update in the execute cycle itself.
- Flag register updates on the rising clk edge:
  - FlagWrite[1]: Flags[3:2] <= ALUFlags[3:2].
  - FlagWrite[0]: Flags[1:0] <= ALUFlags[1:0].
  - Halves are independent; a field whose write bit is clear holds its value.
- CondExDelayed <= CondEx on every rising edge (no enable). Writeback and memory states one or more cycles after execute therefore see the pass/fail of the instruction's own flags, unaffected by the instruction's own flag update.
- Outputs (combinational, no added latency):
  - PCWrite = NextPC | (PCS & CondExDelayed)
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
- Simultaneous events:
  - NextPC=1 with PCS=1 and CondExDelayed=0 gives PCWrite=1; fetch always advances the PC.
  - FlagW nonzero while Cond fails leaves Flags unchanged.
- Reset asserted mid-instruction: pending write strobes drop in the same cycle. After release the first cycle has CondExDelayed=0, so no write leaks from the aborted instruction.
- No other state. Complexity is dominated by the condition table, the two-half flag register and the delayed-condition flop.

Test Plan:
- Reset with FLAGS_RESET=0, NextPC=1, RegW=1 -> Flags=0000, PCWrite=1, RegWrite=0, MemWrite=0. Release reset, Cond=1110 -> next cycle RegWrite=1.
- Flags=0000; Cond=1110, FlagW=11, ALUFlags=0100 for one cycle -> Flags=0100. Then Cond=0000 (EQ) -> CondEx=1; one cycle later RegW=1 gives RegWrite=1. With Cond=0001 (NE) instead -> RegWrite=0.
- Flags=0000; FlagW=10, ALUFlags=1111, Cond=1110 -> Flags=1100 (C,V untouched). Then FlagW=01, ALUFlags=0011 -> Flags=1111.
- Condition failure blocks flags: Flags=0000, Cond=0000 (EQ fails), FlagW=11, ALUFlags=1111 -> Flags remains 0000, CondEx=0. Next cycle MemW=1, PCS=1, NextPC=0 -> MemWrite=0, PCWrite=0.
- Signed compares, one row each:
  - Flags=1000, Cond=1011 (LT) -> CondEx=1.
  - Flags=1001, Cond=1010 (GE) -> CondEx=1.
  - Flags=0100, Cond=1100 (GT) -> 0; Cond=1101 (LE) -> 1.
  - Flags=0010, Cond=1000 (HI) -> 1.
  - Cond=1111 -> 0 for all 16 flag values.
- Reset mid-operation: CondExDelayed=1 with RegW=1, MemW=1; assert reset between clock edges -> RegWrite and MemWrite fall to 0 without waiting for a clock edge, and Flags=FLAGS_RESET.
